// File: rtl/draw_screen_mux.sv
// Screen selector: picks one of N_SRC timing-aligned VGA sources, registers it,
// and switches sources only at a frame boundary with a fade through black.
module draw_screen_mux #(
    parameter int N_SRC      = 4,
    parameter int SEL_W      = 2,
    parameter int COUNT_W    = 11,
    parameter int RGB_W      = 12,
    parameter int FADE_SHIFT = 2,
    parameter int RESET_SEL  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         sel_req,
    input  logic [N_SRC*COUNT_W-1:0] src_hcount,
    input  logic [N_SRC*COUNT_W-1:0] src_vcount,
    input  logic [N_SRC-1:0]         src_hsync,
    input  logic [N_SRC-1:0]         src_vsync,
    input  logic [N_SRC-1:0]         src_hblnk,
    input  logic [N_SRC-1:0]         src_vblnk,
    input  logic [N_SRC*RGB_W-1:0]   src_rgb,
    output logic [COUNT_W-1:0]       out_hcount,
    output logic [COUNT_W-1:0]       out_vcount,
    output logic                     out_hsync,
    output logic                     out_vsync,
    output logic                     out_hblnk,
    output logic                     out_vblnk,
    output logic [RGB_W-1:0]         out_rgb,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     busy
);

    localparam int CH_W    = RGB_W / 3;
    localparam int LVL_W   = FADE_SHIFT + 1;
    localparam int LVL_MAX = 1 << FADE_SHIFT;
    localparam int PROD_W  = CH_W + FADE_SHIFT + 1;

    typedef enum logic [1:0] {
        ST_SHOW,
        ST_FADE_OUT,
        ST_FADE_IN
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [LVL_W-1:0]   r_level, w_level_nxt;
    logic [SEL_W-1:0]   r_active_sel, w_active_nxt;
    logic [SEL_W-1:0]   r_pending, w_pending_nxt;
    logic               r_busy;

    logic [COUNT_W-1:0] r_hcount, r_vcount;
    logic               r_hsync, r_vsync, r_hblnk, r_vblnk;
    logic [RGB_W-1:0]   r_rgb;

    logic [COUNT_W-1:0] w_hc, w_vc;
    logic               w_hs, w_vs, w_hb, w_vb;
    logic [RGB_W-1:0]   w_rgb, w_faded;
    logic [PROD_W-1:0]  w_prod;
    logic               w_frame_tick, w_req_valid;

    // Source select: a compare loop keeps the mux safe when N_SRC is not a power of two.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_hc  = '0;
        w_vc  = '0;
        w_hs  = 1'b0;
        w_vs  = 1'b0;
        w_hb  = 1'b0;
        w_vb  = 1'b0;
        w_rgb = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_active_sel == SEL_W'(i)) begin
                w_hc  = src_hcount[i*COUNT_W +: COUNT_W];
                w_vc  = src_vcount[i*COUNT_W +: COUNT_W];
                w_hs  = src_hsync[i];
                w_vs  = src_vsync[i];
                w_hb  = src_hblnk[i];
                w_vb  = src_vblnk[i];
                w_rgb = src_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    assign w_frame_tick = (w_hc == '0) && (w_vc == '0);
    assign w_req_valid  = ({1'b0, sel_req} < (SEL_W+1)'(N_SRC));

    // Per-channel fade: product is wide enough that level == LVL_MAX returns c exactly.
    always_comb begin
        w_faded = '0;
        w_prod  = '0;
        for (int ch = 0; ch < 3; ch++) begin
            w_prod = PROD_W'(w_rgb[ch*CH_W +: CH_W]) * PROD_W'(r_level);
            w_faded[ch*CH_W +: CH_W] = CH_W'(w_prod >> FADE_SHIFT);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_level_nxt   = r_level;
        w_active_nxt  = r_active_sel;
        w_pending_nxt = r_pending;
        case (r_state)
            ST_SHOW: begin
                if (w_frame_tick && w_req_valid && (sel_req != r_active_sel)) begin
                    w_pending_nxt = sel_req;
                    w_level_nxt   = r_level - LVL_W'(1);
                    // With FADE_SHIFT == 0 the first step already reaches black.
                    if (r_level == LVL_W'(1)) begin
                        w_active_nxt = sel_req;
                        w_state_nxt  = ST_FADE_IN;
                    end else begin
                        w_state_nxt  = ST_FADE_OUT;
                    end
                end
            end
            ST_FADE_OUT: begin
                if (w_req_valid) begin
                    w_pending_nxt = sel_req;
                end
                if (w_frame_tick) begin
                    w_level_nxt = r_level - LVL_W'(1);
                    if (r_level == LVL_W'(1)) begin
                        w_active_nxt = w_pending_nxt;
                        w_state_nxt  = ST_FADE_IN;
                    end
                end
            end
            ST_FADE_IN: begin
                if (w_frame_tick) begin
                    w_level_nxt = r_level + LVL_W'(1);
                    if (w_level_nxt == LVL_W'(LVL_MAX)) begin
                        w_state_nxt = ST_SHOW;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SHOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state      <= ST_SHOW;
            r_level      <= LVL_W'(LVL_MAX);
            r_active_sel <= SEL_W'(RESET_SEL);
            r_pending    <= SEL_W'(RESET_SEL);
            r_busy       <= 1'b0;
            r_hcount     <= '0;
            r_vcount     <= '0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_hblnk      <= 1'b0;
            r_vblnk      <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_active_sel <= w_active_nxt;
            r_pending    <= w_pending_nxt;
            r_busy       <= (w_state_nxt != ST_SHOW);
            r_hcount     <= w_hc;
            r_vcount     <= w_vc;
            r_hsync      <= w_hs;
            r_vsync      <= w_vs;
            r_hblnk      <= w_hb;
            r_vblnk      <= w_vb;
            r_rgb        <= (w_hb || w_vb) ? '0 : w_faded;
        end
    end

    assign out_hcount = r_hcount;
    assign out_vcount = r_vcount;
    assign out_hsync  = r_hsync;
    assign out_vsync  = r_vsync;
    assign out_hblnk  = r_hblnk;
    assign out_vblnk  = r_vblnk;
    assign out_rgb    = r_rgb;
    assign active_sel = r_active_sel;
    assign busy       = r_busy;

endmodule

// File: tb/tb_draw_screen_mux.sv
// Directed bench for draw_screen_mux: a tiny 8x4 frame shared by four sources,
// one instance with FADE_SHIFT=2 and one with FADE_SHIFT=0 on the same inputs.
module tb_draw_screen_mux;

    localparam int N_SRC   = 4;
    localparam int SEL_W   = 3;
    localparam int COUNT_W = 11;
    localparam int RGB_W   = 12;

    logic clk = 1'b0;
    logic rst;
    logic [SEL_W-1:0] sel_req;
    logic [COUNT_W-1:0] hc, vc;
    logic [N_SRC-1:0] force_hb;

    logic [N_SRC*COUNT_W-1:0] src_hcount, src_vcount;
    logic [N_SRC-1:0] src_hsync, src_vsync, src_hblnk, src_vblnk;
    logic [N_SRC*RGB_W-1:0] src_rgb;

    logic [COUNT_W-1:0] out_hcount, out_vcount, f0_hcount, f0_vcount;
    logic out_hsync, out_vsync, out_hblnk, out_vblnk;
    logic f0_hsync, f0_vsync, f0_hblnk, f0_vblnk;
    logic [RGB_W-1:0] out_rgb, f0_rgb;
    logic [SEL_W-1:0] active_sel, f0_active_sel;
    logic busy, f0_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Shared timing: visible for hc<6 and vc<3, hsync at hc==3, vsync on line 3.
    assign src_hcount = {N_SRC{hc}};
    assign src_vcount = {N_SRC{vc}};
    assign src_hsync  = {N_SRC{hc == 11'd3}};
    assign src_vsync  = {N_SRC{vc == 11'd3}};
    assign src_hblnk  = {N_SRC{hc >= 11'd6}} | force_hb;
    assign src_vblnk  = {N_SRC{vc >= 11'd3}};
    assign src_rgb    = {12'hFA5, 12'hF80, 12'h8C4, 12'hFFF};

    draw_screen_mux #(
        .N_SRC(N_SRC), .SEL_W(SEL_W), .COUNT_W(COUNT_W), .RGB_W(RGB_W),
        .FADE_SHIFT(2), .RESET_SEL(0)
    ) dut (
        .clk(clk), .rst(rst), .sel_req(sel_req),
        .src_hcount(src_hcount), .src_vcount(src_vcount),
        .src_hsync(src_hsync), .src_vsync(src_vsync),
        .src_hblnk(src_hblnk), .src_vblnk(src_vblnk), .src_rgb(src_rgb),
        .out_hcount(out_hcount), .out_vcount(out_vcount),
        .out_hsync(out_hsync), .out_vsync(out_vsync),
        .out_hblnk(out_hblnk), .out_vblnk(out_vblnk), .out_rgb(out_rgb),
        .active_sel(active_sel), .busy(busy)
    );

    draw_screen_mux #(
        .N_SRC(N_SRC), .SEL_W(SEL_W), .COUNT_W(COUNT_W), .RGB_W(RGB_W),
        .FADE_SHIFT(0), .RESET_SEL(0)
    ) dut_f0 (
        .clk(clk), .rst(rst), .sel_req(sel_req),
        .src_hcount(src_hcount), .src_vcount(src_vcount),
        .src_hsync(src_hsync), .src_vsync(src_vsync),
        .src_hblnk(src_hblnk), .src_vblnk(src_vblnk), .src_rgb(src_rgb),
        .out_hcount(f0_hcount), .out_vcount(f0_vcount),
        .out_hsync(f0_hsync), .out_vsync(f0_vsync),
        .out_hblnk(f0_hblnk), .out_vblnk(f0_vblnk), .out_rgb(f0_rgb),
        .active_sel(f0_active_sel), .busy(f0_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs now hold the pixel presented before the edge; then advance timing.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (hc == 11'd7) begin
            hc = '0;
            vc = (vc == 11'd3) ? 11'd0 : vc + 11'd1;
        end else begin
            hc = hc + 11'd1;
        end
    endtask

    task automatic goto(input int h, input int v);
        bit found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (hc == 11'(h) && vc == 11'(v)) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check("goto_bound", 32'(found), 32'd1);
    endtask

    // Clock through the next frame_tick and register pixel (1,0) of the new frame.
    task automatic frame();
        goto(0, 0);
        cyc();
        cyc();
    endtask

    initial begin
        rst      = 1'b1;
        sel_req  = '0;
        force_hb = '0;
        hc       = '0;
        vc       = '0;

        // Reset held with sources running.
        repeat (3) cyc();
        check("rst_hcount", 32'(out_hcount), 32'd0);
        check("rst_hsync",  32'(out_hsync),  32'd0);
        check("rst_rgb",    32'(out_rgb),    32'h000);
        check("rst_active", 32'(active_sel), 32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        rst = 1'b0;
        cyc();                                   // pixel (3,0) of src0
        check("rel_hcount", 32'(out_hcount), 32'd3);
        check("rel_hsync",  32'(out_hsync),  32'd1);
        check("rel_rgb",    32'(out_rgb),    32'hFFF);
        cyc();
        check("rel_hcount2", 32'(out_hcount), 32'd4);

        // Request 1 mid-frame: nothing changes before the tick.
        sel_req = 3'd1;
        goto(2, 1);
        cyc();
        check("pre_tick_rgb",  32'(out_rgb),    32'hFFF);
        check("pre_tick_busy", 32'(busy),       32'd0);
        frame();
        check("fo3_rgb",  32'(out_rgb), 32'hBBB);
        check("fo3_busy", 32'(busy),    32'd1);
        frame();
        check("fo2_rgb", 32'(out_rgb), 32'h777);
        frame();
        check("fo1_rgb", 32'(out_rgb), 32'h333);
        frame();
        check("fo0_rgb",    32'(out_rgb),    32'h000);
        check("fo0_active", 32'(active_sel), 32'd1);
        frame();
        check("fi1_rgb", 32'(out_rgb), 32'h231);
        frame();
        check("fi2_rgb", 32'(out_rgb), 32'h462);
        frame();
        check("fi3_rgb",  32'(out_rgb), 32'h693);
        check("fi3_busy", 32'(busy),    32'd1);
        frame();
        check("fi4_rgb",  32'(out_rgb), 32'h8C4);
        check("fi4_busy", 32'(busy),    32'd0);

        // Latest valid request wins during fade-out; 7 is ignored.
        sel_req = 3'd3;
        frame();
        check("t4_fo3_rgb", 32'(out_rgb), 32'h693);
        sel_req = 3'd1;
        repeat (5) cyc();
        sel_req = 3'd3;
        repeat (5) cyc();
        sel_req = 3'd7;
        frame();
        frame();
        frame();
        check("t4_switch_active", 32'(active_sel), 32'd3);
        check("t4_switch_rgb",    32'(out_rgb),    32'h000);
        sel_req = 3'd2;
        frame();
        check("t4_fi_ignore_active", 32'(active_sel), 32'd3);
        check("t4_fi1_rgb",          32'(out_rgb),    32'h321);
        frame();
        check("t4_fi2_rgb", 32'(out_rgb), 32'h752);
        frame();
        check("t4_fi3_rgb", 32'(out_rgb), 32'hB73);
        frame();
        check("t4_show_rgb",  32'(out_rgb), 32'hFA5);
        check("t4_show_busy", 32'(busy),    32'd0);
        frame();
        check("t4_serv_busy", 32'(busy),    32'd1);
        check("t4_serv_rgb",  32'(out_rgb), 32'hB73);
        repeat (7) frame();
        check("t4_final_active", 32'(active_sel), 32'd2);
        check("t4_final_busy",   32'(busy),       32'd0);

        // Source 2 steady: visible colour, blanking mask, sync pass-through.
        goto(2, 1);
        cyc();
        check("t2_rgb", 32'(out_rgb), 32'hF80);
        goto(3, 1);
        force_hb[2] = 1'b1;
        cyc();
        check("t2_hb_rgb",    32'(out_rgb),    32'h000);
        check("t2_hb_hsync",  32'(out_hsync),  32'd1);
        check("t2_hb_hblnk",  32'(out_hblnk),  32'd1);
        check("t2_hb_vcount", 32'(out_vcount), 32'd1);
        force_hb = '0;
        goto(2, 3);
        cyc();
        check("t2_vb_rgb",   32'(out_rgb),   32'h000);
        check("t2_vb_vblnk", 32'(out_vblnk), 32'd1);
        check("t2_vb_vsync", 32'(out_vsync), 32'd1);
        goto(2, 1);
        force_hb[0] = 1'b1;
        cyc();
        check("t2_other_hb_rgb", 32'(out_rgb), 32'hF80);
        force_hb = '0;

        // Reset during fade-out at level 1 discards the pending switch.
        sel_req = 3'd3;
        frame();
        check("t6_fo3_rgb", 32'(out_rgb), 32'hB60);
        frame();
        check("t6_fo2_rgb", 32'(out_rgb), 32'h740);
        frame();
        check("t6_fo1_rgb", 32'(out_rgb), 32'h320);
        rst = 1'b1;
        cyc();
        check("t6_rst_rgb",    32'(out_rgb),    32'h000);
        check("t6_rst_active", 32'(active_sel), 32'd0);
        check("t6_rst_busy",   32'(busy),       32'd0);
        rst     = 1'b0;
        sel_req = 3'd0;
        frame();
        check("t6_post_active", 32'(active_sel), 32'd0);
        check("t6_post_busy",   32'(busy),       32'd0);
        check("t6_post_rgb",    32'(out_rgb),    32'hFFF);

        // FADE_SHIFT=0: equal request gave no fade above; now one black frame.
        check("t5_same_busy", 32'(f0_busy), 32'd0);
        check("t5_same_rgb",  32'(f0_rgb),  32'hFFF);
        sel_req = 3'd1;
        goto(0, 0);
        cyc();
        check("t5_tick_busy",   32'(f0_busy),       32'd1);
        check("t5_tick_active", 32'(f0_active_sel), 32'd1);
        cyc();
        check("t5_black_rgb", 32'(f0_rgb), 32'h000);
        goto(2, 2);
        cyc();
        check("t5_black_mid", 32'(f0_rgb), 32'h000);
        frame();
        check("t5_show_rgb",  32'(f0_rgb),  32'h8C4);
        check("t5_show_busy", 32'(f0_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
